icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_ctrl.sv | 70 +++++++
 rtl/icache.sv | 112 +++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and field layout for the direct-mapped instruction cache.
// Default layout: 16-byte lines, 8 lines, 10-bit PC lookup window.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    localparam int WORD_W      = 32;
    localparam int LINE_W      = 128;
    localparam int OFFSET_LSB  = 2;
    localparam int OFFSET_W    = 2;
    localparam int INDEX_LSB   = OFFSET_LSB + OFFSET_W;
    localparam int INDEX_W     = 3;
    localparam int TAG_LSB     = INDEX_LSB + INDEX_W;
    localparam int TAG_W       = 3;
    localparam int LINE_ADDR_W = TAG_W + INDEX_W;
    localparam int STAT_W      = 16;

endpackage

// File: rtl/icache_ctrl.sv
// Miss-handling FSM for icache: CPU stall, memory line-read handshake and
// the one-cycle fill strobe that writes the returned line into the arrays.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int LA_W = LINE_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_hit,
    input  logic [LA_W-1:0] req_line_addr,
    input  logic            mem_busywait,
    output state_t          state,
    output logic            busywait,
    output logic            mem_read,
    output logic [LA_W-1:0] mem_address,
    output logic            fill
);

    state_t next_state;

    // State register; the missing line address is captured as the miss is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_address <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && !lookup_hit) begin
                mem_address <= req_line_addr;
            end else begin
                mem_address <= mem_address;
            end
        end
    end

    // Next-state and handshake decode; a miss stalls the CPU in the same cycle.
    always_comb begin
        next_state = state;
        busywait   = 1'b1;
        mem_read   = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                busywait = !lookup_hit;
                if (!lookup_hit) begin
                    next_state = MEM_READ;
                end else begin
                    next_state = IDLE;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    next_state = UPDATE;
                end else begin
                    next_state = MEM_READ;
                end
            end
            UPDATE: begin
                fill       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-cycle hits and blocking line fill.
// Optional macro ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache
    import icache_pkg::*;
#(
    parameter  int ADDR_W    = TAG_LSB + TAG_W,
    parameter  int BLOCKS    = 1 << INDEX_W,
    parameter  int WORDS     = LINE_W / WORD_W,
    localparam int OFF_W     = $clog2(WORDS),
    localparam int IDX_W     = $clog2(BLOCKS),
    localparam int TG_W      = ADDR_W - IDX_W - OFF_W - OFFSET_LSB,
    localparam int LA_W      = TG_W + IDX_W,
    localparam int LINE_BITS = WORDS * WORD_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          PC,
    output logic [WORD_W-1:0]    INSTRUCTION,
    output logic                 busywait,
    output logic [LA_W-1:0]      mem_address,
    output logic                 mem_read,
    input  logic [LINE_BITS-1:0] mem_readdata,
    input  logic                 mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]    hit_count,
    output logic [STAT_W-1:0]    miss_count
`endif
);

    logic [LINE_BITS-1:0] data_array [BLOCKS];
    logic [TG_W-1:0]      tag_array  [BLOCKS];
    logic [BLOCKS-1:0]    valid;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TG_W-1:0]  pc_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TG_W-1:0]  fill_tag;
    logic             lookup_hit;
    logic             hit;
    logic             fill;
    state_t           state;
    logic             unused_pc;

    // Upper PC bits alias onto the same lines; byte offset never matters for fetch.
    assign pc_off    = PC[OFFSET_LSB +: OFF_W];
    assign pc_idx    = PC[OFFSET_LSB + OFF_W +: IDX_W];
    assign pc_tag    = PC[OFFSET_LSB + OFF_W + IDX_W +: TG_W];
    assign unused_pc = ^{PC[31:ADDR_W], PC[OFFSET_LSB-1:0]};

    assign fill_idx = mem_address[IDX_W-1:0];
    assign fill_tag = mem_address[LA_W-1:IDX_W];

    assign lookup_hit  = valid[pc_idx] && (tag_array[pc_idx] == pc_tag);
    assign hit         = lookup_hit && (state == IDLE);
    assign INSTRUCTION = data_array[pc_idx][{pc_off, 5'd0} +: WORD_W];

    icache_ctrl #(
        .LA_W (LA_W)
    ) u_ctrl (
        .clk           (CLK),
        .rst_n         (RESET),
        .lookup_hit    (lookup_hit),
        .req_line_addr ({pc_tag, pc_idx}),
        .mem_busywait  (mem_busywait),
        .state         (state),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_address   (mem_address),
        .fill          (fill)
    );

    // Line storage; reset clears data too so the stalled INSTRUCTION is never X.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid <= '0;
            for (int i = 0; i < BLOCKS; i++) begin
                data_array[i] <= '0;
                tag_array[i]  <= '0;
            end
        end else if (fill) begin
            data_array[fill_idx] <= mem_readdata;
            tag_array[fill_idx]  <= fill_tag;
            valid[fill_idx]      <= 1'b1;
        end else begin
            valid <= valid;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating counters: every IDLE hit cycle, and every accepted miss.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != {STAT_W{1'b1}}) begin
                hit_count <= hit_count + 16'd1;
            end else begin
                hit_count <= hit_count;
            end
            if (state == IDLE && !lookup_hit && miss_count != {STAT_W{1'b1}}) begin
                miss_count <= miss_count + 16'd1;
            end else begin
                miss_count <= miss_count;
            end
        end
    end
`endif

endmodule
